// File: rtl/fb_scan_hub75.sv
// Scans one 64x64 RGB332 screen out of the dual-screen pixel memory and drives
// a 1/32-scan 64x64 HUB75 panel using 3 bit-planes with binary-weighted OE time.
module fb_scan_hub75 #(
    parameter int DELAY_UNIT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        selector,
    output logic [12:0] rd_addr,
    output logic        rd_en,
    input  logic [7:0]  rd_data,
    output logic        r0,
    output logic        g0,
    output logic        b0,
    output logic        r1,
    output logic        g1,
    output logic        b1,
    output logic [4:0]  row_addr,
    output logic        panel_clk,
    output logic        latch,
    output logic        oe_n,
    output logic        frame_done,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_UP  = 3'd1,
        RD_LO  = 3'd2,
        CLK_LO = 3'd3,
        CLK_HI = 3'd4,
        LATCH  = 3'd5,
        SHOW   = 3'd6
    } state_t;

    localparam logic [13:0] DELAY_BASE = 14'(DELAY_UNIT);

    state_t      state;
    state_t      next_state;
    logic [5:0]  col;
    logic [4:0]  row;
    logic [1:0]  plane;
    logic        sel_q;
    logic [13:0] show_cnt;
    logic [7:0]  pix_up;
    logic        show_done;
    logic        frame_end;

    // Blue carries only 2 bits, so it is widened to {B1,B0,B1} before slicing.
    function automatic logic [2:0] plane_bits(input logic [7:0] px, input logic [1:0] p);
        logic [2:0] blue3;
        blue3 = {px[1], px[0], px[1]};
        case (p)
            2'd0:    plane_bits = {px[5], px[2], blue3[0]};
            2'd1:    plane_bits = {px[6], px[3], blue3[1]};
            default: plane_bits = {px[7], px[4], blue3[2]};
        endcase
    endfunction

    assign show_done = (state == SHOW) && (show_cnt == 14'd1);
    assign frame_end = show_done && (plane == 2'd2) && (row == 5'd31);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Memory port: rd_en/rd_addr are issued for one cycle and rd_data is
    // valid on the following cycle with no back-pressure; the upper pixel is
    // requested in RD_UP and the lower one in RD_LO.
    always_comb begin
        next_state = state;
        rd_en      = 1'b0;
        rd_addr    = 13'd0;
        case (state)
            IDLE: begin
                if (init) next_state = RD_UP;
            end
            RD_UP: begin
                rd_en      = 1'b1;
                rd_addr    = {sel_q, 1'b0, row, col};
                next_state = RD_LO;
            end
            RD_LO: begin
                rd_en      = 1'b1;
                rd_addr    = {sel_q, 1'b1, row, col};
                next_state = CLK_LO;
            end
            CLK_LO: next_state = CLK_HI;
            CLK_HI: next_state = (col == 6'd63) ? LATCH : RD_UP;
            LATCH:  next_state = SHOW;
            SHOW: begin
                if (show_done) next_state = init ? RD_UP : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Panel outputs are registered one cycle behind the state, so colour
    // settles a full cycle before panel_clk rises and latch lands while blanked.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col        <= 6'd0;
            row        <= 5'd0;
            plane      <= 2'd0;
            sel_q      <= 1'b0;
            show_cnt   <= 14'd0;
            pix_up     <= 8'd0;
            r0         <= 1'b0;
            g0         <= 1'b0;
            b0         <= 1'b0;
            r1         <= 1'b0;
            g1         <= 1'b0;
            b1         <= 1'b0;
            row_addr   <= 5'd0;
            panel_clk  <= 1'b0;
            latch      <= 1'b0;
            oe_n       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            panel_clk  <= (state == CLK_HI);
            latch      <= (state == LATCH);
            oe_n       <= (state != SHOW);
            frame_done <= frame_end;
            case (state)
                IDLE: begin
                    {r0, g0, b0, r1, g1, b1} <= 6'd0;
                    row_addr <= 5'd0;
                    if (init) begin
                        sel_q <= selector;
                        col   <= 6'd0;
                        row   <= 5'd0;
                        plane <= 2'd0;
                    end
                end
                RD_LO: pix_up <= rd_data;
                CLK_LO: begin
                    {r0, g0, b0} <= plane_bits(pix_up, plane);
                    {r1, g1, b1} <= plane_bits(rd_data, plane);
                end
                CLK_HI: col <= (col == 6'd63) ? 6'd0 : col + 6'd1;
                LATCH: begin
                    row_addr <= row;
                    show_cnt <= DELAY_BASE << plane;
                end
                SHOW: begin
                    show_cnt <= show_cnt - 14'd1;
                    if (show_done) begin
                        if (plane != 2'd2) begin
                            plane <= plane + 2'd1;
                        end else begin
                            plane <= 2'd0;
                            if (row != 5'd31) begin
                                row <= row + 5'd1;
                            end else begin
                                row   <= 5'd0;
                                sel_q <= selector;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
